// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register and its helpers.
package pipe_pkg;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_FLAG_W  = 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy of the stage; the encoding doubles as the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear, for performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: instruction plus flags through valid/ready, with flush,
// optional 2-entry skid buffer, NOP masking of empty outputs and a stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int FLAG_W  = DEF_FLAG_W,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [FLAG_W-1:0]  in_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [FLAG_W-1:0]  out_flags,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [1:0]         dbg_state
);

    localparam int EW = INSTR_W + FLAG_W;

    // Handshake: a transfer happens on an edge only when valid and ready are both
    // high; the producer may not rely on ready before asserting valid.
    stage_state_e    state_q, state_d;
    logic [EW-1:0]   main_q, main_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic            ready_q, ready_d;
    logic            accept;
    logic            consume;
    logic [EW-1:0]   in_entry;

    assign in_entry  = {in_instr, in_flags};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? ready_q : (out_ready || (state_q == ST_EMPTY));
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_entry;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_d = in_entry;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = in_entry;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any handshake; the simultaneous input is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
        end
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign out_instr = out_valid ? main_q[EW-1:FLAG_W] : INSTR_W'(NOP_INSTR);
    assign out_flags = out_valid ? main_q[FLAG_W-1:0] : '0;
    assign dbg_state = state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register that replaces the fixed per-stage latches (F/D, D/E, E/M, M/W) with one reusable block.
- Carries an instruction word plus a bundle of side-band flag bits through a valid/ready handshake.
- Supports flush and an optional 2-entry skid mode, so back-pressure never needs a combinational ready path across stages.
- Forces a NOP (all-zero instruction, zero flags) on its outputs whenever it holds no valid entry.

Parameters:
- INSTR_W, 32, instruction word width.
- FLAG_W, 1, side-band flag width (per-instruction control bits such as write-enable or change flags); must be at least 1.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low: state clears on a clk rising edge while rst==0.
- flush  input  1  discard all held entries this edge.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  block accepts an entry this cycle.
- in_instr  input  INSTR_W  instruction from the upstream stage.
- in_flags  input  FLAG_W  side-band bits from the upstream stage.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_instr  output  INSTR_W  head instruction; 0 when out_valid==0.
- out_flags  output  FLAG_W  head flags; 0 when out_valid==0.
- stall_cnt  output  CNT_W  count of cycles with out_valid && !out_ready.

Behaviour:
- Handshake definitions:
  - Accept = in_valid && in_ready.
  - Consume = out_valid && out_ready.
  - Data on in_instr/in_flags is sampled only on accept.
  - Outputs hold stable while out_valid && !out_ready.
- Reset (rst==0 at an edge):
  - All entries invalid; out_valid=0, out_instr=0, out_flags=0, stall_cnt=0.
  - in_ready=1 after reset in both modes.
  - Reset overrides flush and any handshake in the same cycle.
- Latency: one cycle. An entry accepted at edge N appears on the outputs after edge N, with no bypass from in_* to out_*.
- NOP masking: out_instr and out_flags are ANDed with out_valid, so stale register contents are never visible.
- SKID=0 (one register, main):
  - in_ready = out_ready || !main_valid (combinational).
  - On accept, main <= input and main_valid <= 1.
  - Consume without accept: main_valid <= 0.
  - Consume plus accept in the same cycle: main is replaced; throughput is 1 per cycle.
- SKID=1: registers main and skid; state machine over {EMPTY, ONE, TWO}.
  - in_ready = (state != TWO), and is a registered value.
  - EMPTY: accept -> ONE (load main).
  - ONE:
    - accept && consume -> ONE (load main).
    - accept && !consume -> TWO (load skid).
    - consume only -> EMPTY.
  - TWO: in_ready=0. Consume -> ONE, with main <= skid.
  - Full throughput at 1 per cycle with out_ready held high; one extra slot absorbs a single-cycle out_ready drop.
- Flush (rst==1, flush==1):
  - All entries invalid, state -> EMPTY, regardless of in_valid/out_ready in that cycle.
  - The simultaneous input is dropped, not accepted. Upstream must treat in_ready as irrelevant that cycle; the team's hazard unit flushes both sides together.
  - stall_cnt is not cleared by flush.
- stall_cnt:
  - Increments by 1 each edge where out_valid && !out_ready and rst==1.
  - Saturates at all-ones; no wrap.
- Flag bits travel in lock-step with their instruction in both registers, never separated.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTR = 32'h0000_0000.
  - The state encoding for EMPTY/ONE/TWO as a 2-bit localparam set.
  - Default INSTR_W / FLAG_W.
- One sub-module is natural: sat_counter (CNT_W parameter, inc, rst), reusable for other performance counters.
- Stage instances are then pipe_stage_reg with FLAG_W sized per stage.

Test Plan:
1. Reset: hold rst=0 for 2 edges with in_valid=1, in_instr=32'h1234_5678 -> out_valid=0, out_instr=0, stall_cnt=0, in_ready=1 after reset.
2. Streaming, SKID=1: out_ready=1, push instrs 1,2,3,4 on consecutive cycles -> out_instr=1,2,3,4 on the 4 following cycles, in_ready stays 1, stall_cnt=0.
3. Back-pressure:
   - Push 0xA, 0xB, 0xC with out_ready=0 from cycle 1 -> 0xA held, 0xB in skid, in_ready=0, 0xC not accepted.
   - Then out_ready=1 -> outputs 0xA, 0xB, then 0xC after upstream re-offers it.
   - stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
4. Flush in TWO state with in_valid=1, in_instr=0xD -> next cycle out_valid=0, out_instr=0, in_ready=1; 0xD never appears.
5. SKID=0 mode: out_ready toggles 1,0,1 while in_valid=1 -> in_ready follows out_ready||!out_valid combinationally, no entry lost or duplicated.
6. Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF; reset then clears it to 0.
